conv_result_streamer: RTL
=========================

Name: conv_result_streamer

Overview:
Reads the pooled convolution results out of the output image RAM after a run and streams them to a byte-wide sink, such as the UART transmitter, over a valid/ready handshake.
It is the read side of the output RAM, which spatial_conv_core results are written into, one DATA_WIDTH word per address.
Each word is serialized MSB byte first, so host tools receive Q(DATA_WIDTH-FRAC_WIDTH).FRAC_WIDTH words big-endian.

Parameters:
ADDR_WIDTH, 16, width of the output RAM address bus
DATA_WIDTH, 32, width of one result word; must be a multiple of 8
OUTPUT_SIZE, 2401, number of words to stream (N_KERNELS*98*98/4 for the 100x100, 3x3 conv, 2x2 pool configuration)
BASE_ADDR, 0, first RAM address read
RD_LATENCY, 2, cycles from ram_rdaddress_o change to valid ram_q_i (registered address plus registered q); legal range 1..4

Ports:
system_clock  in  1  system clock; all logic on the rising edge
global_reset  in  1  asynchronous, active-high reset
start_i  in  1  begin a stream; sampled only in IDLE or DONE
ram_rdaddress_o  out  ADDR_WIDTH  output RAM read address
ram_q_i  in  DATA_WIDTH  output RAM read data
byte_o  out  8  byte to the sink
byte_valid_o  out  1  byte_o is valid
byte_ready_i  in  1  sink accepts byte_o this cycle
busy_o  out  1  high in FETCH and SEND
done_o  out  1  high in DONE
words_sent_o  out  ADDR_WIDTH  count of fully transmitted words

Behaviour:
- Reset values (asynchronous):
  - state = IDLE
  - ram_rdaddress_o = BASE_ADDR
  - byte_o = 0, byte_valid_o = 0
  - busy_o = 0, done_o = 0
  - words_sent_o = 0
  - Internal latency counter = 0, byte index = 0
- States: IDLE, FETCH, SEND, DONE.
- IDLE:
  - On start_i=1, go to FETCH.
  - ram_rdaddress_o = BASE_ADDR, words_sent_o = 0, latency counter = 0.
- FETCH:
  - The address is held constant.
  - The latency counter increments each cycle.
  - When it reaches RD_LATENCY-1, capture ram_q_i into a word register, set byte index = 0, and go to SEND.
  - FETCH therefore lasts exactly RD_LATENCY cycles.
- SEND:
  - byte_valid_o = 1.
  - byte_o = word[DATA_WIDTH-1-8*idx -: 8], MSB byte first.
  - A transfer occurs on a cycle with byte_valid_o && byte_ready_i.
  - While valid && !ready, byte_o must stay stable.
  - On transfer of a non-last byte: idx increments.
  - On transfer of the last byte (idx = DATA_WIDTH/8-1): words_sent_o increments and byte_valid_o deasserts on the next cycle.
    - If words_sent_o+1 == OUTPUT_SIZE, go to DONE.
    - Otherwise ram_rdaddress_o increments, the latency counter is cleared, and the block returns to FETCH.
- DONE:
  - done_o = 1; ram_rdaddress_o and words_sent_o hold.
  - On start_i=1, restart as in IDLE: go to FETCH with the address reloaded to BASE_ADDR and words_sent_o cleared.
- start_i in FETCH or SEND is ignored; there is no mid-stream restart.
- byte_ready_i is don't-care outside SEND.
- Throughput: DATA_WIDTH/8 + RD_LATENCY cycles per word with ready held high.
- The RAM is never written by this block; the write-enable is tied 0 at the top level.
- OUTPUT_SIZE = 0 is illegal. Address wrap beyond 2^ADDR_WIDTH is not handled; the top level guarantees BASE_ADDR+OUTPUT_SIZE <= 2^ADDR_WIDTH.
- global_reset mid-stream:
  - Immediate return to IDLE with byte_valid_o low.
  - A partially sent word is abandoned, not resumed.

Decomposition:
- Shared package cnn_stream_pkg holds:
  - the state enum (IDLE, FETCH, SEND, DONE);
  - the localparam BYTES_PER_WORD = DATA_WIDTH/8;
  - a function computing OUTPUT_SIZE from N_ROWS, N_COLS, KERNEL_SIZE, POOL_SIZE and N_KERNELS, which the conv test top also uses.
- One sub-module, word_serializer, is natural:
  - It has a load/word input and a byte valid/ready output, plus a last-byte flag.
  - The FSM in conv_result_streamer keeps only the address and latency logic.

Test Plan:
1. OUTPUT_SIZE=2, RAM[0]=32'h12345678, RAM[1]=32'hCAFEBABE, ready tied 1, pulse start_i -> bytes 12,34,56,78,CA,FE,BA,BE in order. The first byte_valid_o occurs 2 cycles after FETCH entry, there is 1 valid cycle per byte, done_o rises after the 8th transfer, and words_sent_o=2.
2. Backpressure: same data, byte_ready_i low for 5 cycles while byte 0x56 is presented -> byte_o stays 0x56 and valid stays 1 throughout, and no byte is dropped or duplicated.
3. start_i pulsed during SEND of word 0 -> ignored, and the stream completes normally with exactly 8 bytes. A start_i in DONE restarts from BASE_ADDR and the same 8 bytes repeat.
4. global_reset asserted after the 3rd byte -> next cycle byte_valid_o=0, busy_o=0, ram_rdaddress_o=BASE_ADDR, words_sent_o=0. A new start then emits 12 first.
5. RD_LATENCY=1 and RD_LATENCY=4 with a RAM model of matching latency -> correct bytes in both cases, with per-word spacing of 5 and 8 cycles respectively (ready tied 1).
6. Full run with OUTPUT_SIZE=2401 and RAM[i]=i -> 9604 bytes; the last word reads 00,00,09,60, and words_sent_o=2401 at DONE.

Source files
------------

// File: rtl/cnn_stream_pkg.sv
// Shared types and sizing helpers for the conv result read-out path.
package cnn_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } stream_state_t;

  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int BYTES_PER_WORD     = DATA_WIDTH_DEFAULT / 8;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

  // Words left after a valid KxK convolution followed by PxP pooling, for all kernels.
  function automatic int conv_output_size(input int n_rows, input int n_cols,
                                          input int kernel_size, input int pool_size,
                                          input int n_kernels);
    return n_kernels * ((n_rows - kernel_size + 1) / pool_size)
                     * ((n_cols - kernel_size + 1) / pool_size);
  endfunction

endpackage

// File: rtl/conv_result_streamer_word_serializer.sv
// Splits one loaded word into bytes, MSB first; byte appears the cycle after load.
// Holds the current byte while byte_ready is low; last_byte_sent pulses on the final transfer.
module word_serializer
  import cnn_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  system_clock,
  input  logic                  global_reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [7:0]            byte_data,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic                  last_byte_sent
);

  localparam int BPW   = bytes_per_word(DATA_WIDTH);
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

  logic [DATA_WIDTH-1:0] shreg;
  logic [IDX_W-1:0]      idx;
  logic                  xfer;

  assign xfer           = byte_valid && byte_ready;
  assign last_byte_sent = xfer && (idx == LAST_IDX);
  // The top byte of the shift register is always word[DATA_WIDTH-1-8*idx -: 8].
  assign byte_data      = shreg[DATA_WIDTH-1 -: 8];

  always_ff @(posedge system_clock or posedge global_reset) begin
    if (global_reset) begin
      shreg      <= '0;
      idx        <= '0;
      byte_valid <= 1'b0;
    end else if (load) begin
      shreg      <= word;
      idx        <= '0;
      byte_valid <= 1'b1;
    end else if (xfer) begin
      shreg <= shreg << 8;
      if (idx == LAST_IDX) begin
        idx        <= '0;
        byte_valid <= 1'b0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_result_streamer.sv
// Streams OUTPUT_SIZE result words from the output RAM as big-endian bytes.
// DATA_WIDTH/8 + RD_LATENCY cycles per word at full rate; stalls in place while byte_ready_i is low.
module conv_result_streamer
  import cnn_stream_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int OUTPUT_SIZE = 2401,
  parameter int BASE_ADDR   = 0,
  parameter int RD_LATENCY  = 2
) (
  input  logic                  system_clock,
  input  logic                  global_reset,
  input  logic                  start_i,
  output logic [ADDR_WIDTH-1:0] ram_rdaddress_o,
  input  logic [DATA_WIDTH-1:0] ram_q_i,
  output logic [7:0]            byte_o,
  output logic                  byte_valid_o,
  input  logic                  byte_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] words_sent_o
);

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0]      LAT_LAST  = CNT_W'(RD_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(OUTPUT_SIZE - 1);

  stream_state_t    state;
  logic [CNT_W-1:0] lat_cnt;
  logic             load;
  logic             last_byte_sent;

  // RAM data is valid on the final FETCH cycle, so it is captured on that edge.
  assign load = (state == FETCH) && (lat_cnt == LAT_LAST);

  always_ff @(posedge system_clock or posedge global_reset) begin
    if (global_reset) begin
      state           <= IDLE;
      ram_rdaddress_o <= BASE;
      words_sent_o    <= '0;
      lat_cnt         <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          lat_cnt <= '0;
          if (start_i) begin
            state           <= FETCH;
            ram_rdaddress_o <= BASE;
            words_sent_o    <= '0;
            busy_o          <= 1'b1;
            done_o          <= 1'b0;
          end
        end
        FETCH: begin
          if (load) begin
            state   <= SEND;
            lat_cnt <= '0;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        SEND: begin
          if (last_byte_sent) begin
            words_sent_o <= words_sent_o + 1'b1;
            if (words_sent_o == LAST_WORD) begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              state           <= FETCH;
              ram_rdaddress_o <= ram_rdaddress_o + 1'b1;
              lat_cnt         <= '0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

  word_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_word_serializer (
    .system_clock  (system_clock),
    .global_reset  (global_reset),
    .load          (load),
    .word          (ram_q_i),
    .byte_data     (byte_o),
    .byte_valid    (byte_valid_o),
    .byte_ready    (byte_ready_i),
    .last_byte_sent(last_byte_sent)
  );

endmodule
